// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with Execute-stage forwarding muxes for the ALU operands.
// Define EX_STALL_CNT_EN to add the saturating stall_cycles counter port.
module ex_operand_stage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [1:0]        id_ra,
    input  logic [1:0]        id_rb,
    input  logic [DATA_W-1:0] id_rdata_a,
    input  logic [DATA_W-1:0] id_rdata_b,
    input  logic [1:0]        id_has_hazard,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush_ex,
    input  logic              stall,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    input  logic [DATA_W-1:0] fwd_mem_alu,
    input  logic [DATA_W-1:0] fwd_wb_data,
    input  logic [DATA_W-1:0] fwd_wb_in,
    output logic [1:0]        ex_ra,
    output logic [1:0]        ex_rb,
    output logic [1:0]        ex_has_hazard,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              ex_issue,
    output logic              id_ready
`ifdef EX_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    logic              valid_q,   valid_d;
    logic [1:0]        ra_q,      ra_d;
    logic [1:0]        rb_q,      rb_d;
    logic [1:0]        hazard_q,  hazard_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    // Forwarding muxes feeding the ALU
    always_comb begin
        op_a = rdata_a_q;
        case (forward_a)
            2'b01:   op_a = fwd_mem_alu;
            2'b10:   op_a = fwd_wb_data;
            2'b11:   op_a = fwd_wb_in;
            default: op_a = rdata_a_q;
        endcase
    end

    always_comb begin
        op_b = rdata_b_q;
        case (forward_b)
            2'b01:   op_b = fwd_mem_alu;
            2'b10:   op_b = fwd_wb_data;
            2'b11:   op_b = fwd_wb_in;
            default: op_b = rdata_b_q;
        endcase
    end

    // Next-state: flush beats stall; a stall re-captures the forwarded operands
    always_comb begin
        valid_d   = valid_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        hazard_d  = hazard_q;
        ctrl_d    = ctrl_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (flush_ex) begin
            valid_d  = 1'b0;
            hazard_d = 2'b00;
        end else if (stall) begin
            rdata_a_d = op_a;
            rdata_b_d = op_b;
        end else begin
            valid_d   = id_valid;
            ra_d      = id_ra;
            rb_d      = id_rb;
            ctrl_d    = id_ctrl;
            rdata_a_d = id_rdata_a;
            rdata_b_d = id_rdata_b;
            hazard_d  = id_valid ? id_has_hazard : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ra_q      <= '0;
            rb_q      <= '0;
            hazard_q  <= '0;
            ctrl_q    <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            valid_q   <= valid_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            hazard_q  <= hazard_d;
            ctrl_q    <= ctrl_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_ra         = ra_q;
    assign ex_rb         = rb_q;
    assign ex_ctrl       = ctrl_q;
    assign ex_has_hazard = hazard_q & {2{valid_q}};
    assign ex_issue      = valid_q & ~stall;
    assign id_ready      = ~stall;

`ifdef EX_STALL_CNT_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts cycles a real instruction is held by a load-use stall, saturating
    always_comb begin
        cnt_d = cnt_q;
        if (stall && valid_q && !flush_ex && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: driver queues per-cycle expectations, negedge monitor checks.
module tb_ex_operand_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [1:0]  id_ra, id_rb;
    logic [7:0]  id_rdata_a, id_rdata_b;
    logic [1:0]  id_has_hazard;
    logic [15:0] id_ctrl;
    logic        flush_ex, stall;
    logic [1:0]  forward_a, forward_b;
    logic [7:0]  fwd_mem_alu, fwd_wb_data, fwd_wb_in;
    logic [1:0]  ex_ra, ex_rb, ex_has_hazard;
    logic        ex_valid;
    logic [15:0] ex_ctrl;
    logic [7:0]  op_a, op_b;
    logic        ex_issue, id_ready;
`ifdef EX_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    ex_operand_stage #(.DATA_W(8), .CTRL_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
        .id_rdata_a(id_rdata_a), .id_rdata_b(id_rdata_b),
        .id_has_hazard(id_has_hazard), .id_ctrl(id_ctrl),
        .flush_ex(flush_ex), .stall(stall),
        .forward_a(forward_a), .forward_b(forward_b),
        .fwd_mem_alu(fwd_mem_alu), .fwd_wb_data(fwd_wb_data), .fwd_wb_in(fwd_wb_in),
        .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_has_hazard(ex_has_hazard),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .op_a(op_a), .op_b(op_b),
        .ex_issue(ex_issue), .id_ready(id_ready)
`ifdef EX_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [9:0]  m;
        logic        v;
        logic [1:0]  ra, rb, hh;
        logic [15:0] ctrl;
        logic [7:0]  a, b;
        logic        iss, rdy;
        logic [15:0] sc;
    } exp_t;

    // mask bits: 0 valid, 1 ra, 2 rb, 3 hazard, 4 ctrl, 5 op_a, 6 op_b, 7 issue, 8 ready, 9 stall_cycles
    localparam logic [9:0] M_ALL = 10'h1FF;
    localparam logic [9:0] M_SC  = 10'h200;
    localparam logic [9:0] M_BUB = 10'h189;
    localparam logic [9:0] M_FLD = 10'h197;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one queued expectation per cycle, checked mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.m[0]) chk(mon_e.name, "ex_valid",      16'(ex_valid),      16'(mon_e.v));
            if (mon_e.m[1]) chk(mon_e.name, "ex_ra",         16'(ex_ra),         16'(mon_e.ra));
            if (mon_e.m[2]) chk(mon_e.name, "ex_rb",         16'(ex_rb),         16'(mon_e.rb));
            if (mon_e.m[3]) chk(mon_e.name, "ex_has_hazard", 16'(ex_has_hazard), 16'(mon_e.hh));
            if (mon_e.m[4]) chk(mon_e.name, "ex_ctrl",       ex_ctrl,            mon_e.ctrl);
            if (mon_e.m[5]) chk(mon_e.name, "op_a",          16'(op_a),          16'(mon_e.a));
            if (mon_e.m[6]) chk(mon_e.name, "op_b",          16'(op_b),          16'(mon_e.b));
            if (mon_e.m[7]) chk(mon_e.name, "ex_issue",      16'(ex_issue),      16'(mon_e.iss));
            if (mon_e.m[8]) chk(mon_e.name, "id_ready",      16'(id_ready),      16'(mon_e.rdy));
`ifdef EX_STALL_CNT_EN
            if (mon_e.m[9]) chk(mon_e.name, "stall_cycles",  stall_cycles,       mon_e.sc);
`endif
        end
    end

    task automatic push(input string nm, input logic [9:0] m, input logic v,
                        input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] hh,
                        input logic [15:0] ctrl, input logic [7:0] a, input logic [7:0] b,
                        input logic iss, input logic rdy, input logic [15:0] sc);
        exp_t e;
        e.name = nm; e.m = m; e.v = v; e.ra = ra; e.rb = rb; e.hh = hh;
        e.ctrl = ctrl; e.a = a; e.b = b; e.iss = iss; e.rdy = rdy; e.sc = sc;
        exp_q.push_back(e);
    endtask

    task automatic id_in(input logic v, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] hh, input logic [15:0] ctrl);
        id_valid = v; id_ra = ra; id_rb = rb; id_rdata_a = a; id_rdata_b = b;
        id_has_hazard = hh; id_ctrl = ctrl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush_ex = 1'b0; stall = 1'b0;
        forward_a = 2'b00; forward_b = 2'b00;
        fwd_mem_alu = 8'hA1; fwd_wb_data = 8'hB2; fwd_wb_in = 8'hC3;
        id_in(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 16'h0000);

        tick();
        push("reset", M_ALL | M_SC, 1'b0, 2'd0, 2'd0, 2'b00, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 16'd0);
        tick();
        rst = 1'b0;
        id_in(1'b1, 2'd1, 2'd2, 8'h12, 8'h34, 2'b11, 16'hBEEF);
        push("reset_hold", M_ALL | M_SC, 1'b0, 2'd0, 2'd0, 2'b00, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 16'd0);

        tick();
        id_in(1'b1, 2'd3, 2'd0, 8'h55, 8'h66, 2'b10, 16'h1234);
        push("plain", M_ALL | M_SC, 1'b1, 2'd1, 2'd2, 2'b11, 16'hBEEF, 8'h12, 8'h34, 1'b1, 1'b1, 16'd0);

        tick();
        forward_a = 2'b01;
        id_in(1'b1, 2'd2, 2'd1, 8'h77, 8'h88, 2'b01, 16'hCAFE);
        push("fwd_a01", M_ALL, 1'b1, 2'd3, 2'd0, 2'b10, 16'h1234, 8'hA1, 8'h66, 1'b1, 1'b1, 16'd0);

        tick();
        forward_a = 2'b10; forward_b = 2'b01;
        id_in(1'b1, 2'd1, 2'd3, 8'h21, 8'h43, 2'b11, 16'h0F0F);
        push("fwd_a10", M_ALL, 1'b1, 2'd2, 2'd1, 2'b01, 16'hCAFE, 8'hB2, 8'hA1, 1'b1, 1'b1, 16'd0);

        tick();
        forward_a = 2'b11; forward_b = 2'b00;
        id_in(1'b1, 2'd2, 2'd2, 8'h99, 8'hAA, 2'b11, 16'h5A5A);
        push("fwd_a11", M_ALL, 1'b1, 2'd1, 2'd3, 2'b11, 16'h0F0F, 8'hC3, 8'h43, 1'b1, 1'b1, 16'd0);

        // Single-cycle load-use stall, then WB forward of the loaded value
        tick();
        forward_a = 2'b00; stall = 1'b1;
        id_in(1'b1, 2'd0, 2'd1, 8'h11, 8'h22, 2'b11, 16'h6666);
        push("stall1", M_ALL | M_SC, 1'b1, 2'd2, 2'd2, 2'b11, 16'h5A5A, 8'h99, 8'hAA, 1'b0, 1'b0, 16'd0);

        tick();
        stall = 1'b0; forward_b = 2'b10; fwd_wb_data = 8'h5E;
        push("stall1_after", M_ALL | M_SC, 1'b1, 2'd2, 2'd2, 2'b11, 16'h5A5A, 8'h99, 8'h5E, 1'b1, 1'b1, 16'd1);

        // Three-cycle stall; first cycle refreshes op_a from WB
        tick();
        stall = 1'b1; forward_a = 2'b10; forward_b = 2'b00;
        id_in(1'b1, 2'd3, 2'd3, 8'h31, 8'h32, 2'b11, 16'h7777);
        push("stall3_c0", M_ALL | M_SC, 1'b1, 2'd0, 2'd1, 2'b11, 16'h6666, 8'h5E, 8'h22, 1'b0, 1'b0, 16'd1);
        tick();
        forward_a = 2'b00;
        push("stall3_c1", M_ALL | M_SC, 1'b1, 2'd0, 2'd1, 2'b11, 16'h6666, 8'h5E, 8'h22, 1'b0, 1'b0, 16'd2);
        tick();
        push("stall3_c2", M_ALL | M_SC, 1'b1, 2'd0, 2'd1, 2'b11, 16'h6666, 8'h5E, 8'h22, 1'b0, 1'b0, 16'd3);
        tick();
        stall = 1'b0;
        push("stall3_end", M_ALL | M_SC, 1'b1, 2'd0, 2'd1, 2'b11, 16'h6666, 8'h5E, 8'h22, 1'b1, 1'b1, 16'd4);

        // Flush together with stall
        tick();
        flush_ex = 1'b1; stall = 1'b1;
        id_in(1'b1, 2'd1, 2'd1, 8'h41, 8'h42, 2'b11, 16'h8888);
        push("flush_stall", M_ALL | M_SC, 1'b1, 2'd3, 2'd3, 2'b11, 16'h7777, 8'h31, 8'h32, 1'b0, 1'b0, 16'd4);
        tick();
        flush_ex = 1'b0; stall = 1'b0;
        id_in(1'b0, 2'd2, 2'd1, 8'h00, 8'h00, 2'b11, 16'hDEAD);
        push("flushed", M_BUB | M_SC, 1'b0, 2'd0, 2'd0, 2'b00, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 16'd4);

        // Bubble with hazard bits set must present no hazard
        tick();
        id_in(1'b1, 2'd1, 2'd2, 8'h13, 8'h24, 2'b01, 16'h9999);
        push("bubble_mask", M_BUB, 1'b0, 2'd0, 2'd0, 2'b00, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 16'd4);
        tick();
        id_in(1'b1, 2'd3, 2'd3, 8'h3A, 8'h3B, 2'b11, 16'hAAAA);
        push("after_bubble", M_ALL, 1'b1, 2'd1, 2'd2, 2'b01, 16'h9999, 8'h13, 8'h24, 1'b1, 1'b1, 16'd4);

        // Reset during a stall
        tick();
        rst = 1'b1; stall = 1'b1;
        push("rst_in_stall", M_ALL | M_SC, 1'b1, 2'd3, 2'd3, 2'b11, 16'hAAAA, 8'h3A, 8'h3B, 1'b0, 1'b0, 16'd4);
        tick();
        rst = 1'b0; stall = 1'b0;
        id_in(1'b1, 2'd1, 2'd1, 8'h01, 8'h02, 2'b00, 16'h0001);
        push("rst_done", M_ALL | M_SC, 1'b0, 2'd0, 2'd0, 2'b00, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 16'd0);

        // Five stall cycles on a valid instruction, then a reset pulse
        tick();
        stall = 1'b1;
        id_in(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 16'h0000);
        push("cnt_s0", M_ALL | M_SC, 1'b1, 2'd1, 2'd1, 2'b00, 16'h0001, 8'h01, 8'h02, 1'b0, 1'b0, 16'd0);
        for (int i = 1; i < 5; i++) begin
            tick();
            push("cnt_sN", M_FLD | M_SC, 1'b1, 2'd1, 2'd1, 2'b00, 16'h0001, 8'h01, 8'h02, 1'b0, 1'b0, 16'(i));
        end
        tick();
        stall = 1'b0; rst = 1'b1;
        push("cnt_five", M_ALL | M_SC, 1'b1, 2'd1, 2'd1, 2'b00, 16'h0001, 8'h01, 8'h02, 1'b1, 1'b1, 16'd5);
        tick();
        rst = 1'b0;
        push("cnt_rst", M_BUB | M_SC, 1'b0, 2'd0, 2'd0, 2'b00, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 16'd0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
